// File: rtl/wb_axis_stream_hub.sv
// Wishbone slave bridging NCH uniform AXI-Stream channels. Each channel has a TX and an RX
// FWFT FIFO plus STATUS/CTRL registers. RX stream reads that find no data time out with an error.
module wb_axis_stream_hub #(
  parameter int unsigned NCH        = 3,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [11:0] BASE_HI    = 12'h300,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [NCH-1:0]    ss_tvalid,
  output logic [NCH*DW-1:0] ss_tdata,
  output logic [NCH-1:0]    ss_tlast,
  input  logic [NCH-1:0]    ss_tready,
  input  logic [NCH-1:0]    sm_tvalid,
  input  logic [NCH*DW-1:0] sm_tdata,
  input  logic [NCH-1:0]    sm_tlast,
  output logic [NCH-1:0]    sm_tready,
  output logic [NCH-1:0]    irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cur_ch;
  logic          cur_we;
  logic [TW-1:0] wait_cnt;
  logic          rdy_en;

  logic [DW:0]   tx_mem [NCH][FIFO_DEPTH];
  logic [DW-1:0] rx_mem [NCH][FIFO_DEPTH];
  logic [CW-1:0] tx_wp [NCH];
  logic [CW-1:0] tx_rp [NCH];
  logic [CW-1:0] rx_wp [NCH];
  logic [CW-1:0] rx_rp [NCH];
  logic [CW-1:0] tx_cnt [NCH];
  logic [CW-1:0] rx_cnt [NCH];

  logic [NCH-1:0] tx_space, rx_has, tx_push, tx_pop, rx_push, rx_pop;
  logic [NCH-1:0] ctrl_wr, op_sel;
  logic [NCH-1:0] last_arm, irq_en, rx_last_seen, timeout_err;

  logic          req, hit, ch_ok, sel_ok, reg_wr, stream_act, timeout_hit;
  logic          op_we, op_space, op_avail;
  logic [3:0]    adr_ch, op_ch;
  logic [DW-1:0] op_rx_data;
  logic [31:0]   reg_rdata;

  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[19:12], wbs_adr_i[6:3], wbs_adr_i[1:0]};

  assign wbs_ack_o = (state == S_ACK);
  assign tx_pop    = ss_tvalid & ss_tready;
  assign rx_push   = sm_tvalid & sm_tready;
  assign irq       = irq_en & rx_has;

  always_comb begin
    ss_tdata  = '0;
    ss_tvalid = '0;
    ss_tlast  = '0;
    sm_tready = '0;
    tx_space  = '0;
    rx_has    = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      tx_cnt[c]    = tx_wp[c] - tx_rp[c];
      rx_cnt[c]    = rx_wp[c] - rx_rp[c];
      tx_space[c]  = tx_cnt[c] < CW'(FIFO_DEPTH);
      rx_has[c]    = rx_cnt[c] != '0;
      ss_tvalid[c] = tx_cnt[c] != '0;
      ss_tdata[c*DW +: DW] = tx_mem[c][tx_rp[c][AW-1:0]][DW-1:0];
      ss_tlast[c]  = ss_tvalid[c] & tx_mem[c][tx_rp[c][AW-1:0]][DW];
      // Ready follows the registered count only; a same-cycle pop never frees a slot early.
      sm_tready[c] = rdy_en & (rx_cnt[c] < CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    req        = wbs_cyc_i & wbs_stb_i;
    hit        = req & (wbs_adr_i[31:20] == BASE_HI);
    adr_ch     = wbs_adr_i[11:8];
    ch_ok      = 32'(adr_ch) < NCH;
    sel_ok     = |wbs_sel_i;
    reg_wr     = (state == S_IDLE) & hit & ch_ok & sel_ok & ~wbs_adr_i[7] & wbs_we_i & wbs_adr_i[2];
    op_ch      = (state == S_IDLE) ? adr_ch : cur_ch;
    op_we      = (state == S_IDLE) ? wbs_we_i : cur_we;
    stream_act = ((state == S_IDLE) & hit & ch_ok & sel_ok & wbs_adr_i[7]) |
                 ((state == S_WAIT) & req);
    op_sel     = '0;
    ctrl_wr    = '0;
    tx_push    = '0;
    rx_pop     = '0;
    op_rx_data = '0;
    reg_rdata  = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      op_sel[c]  = (op_ch == 4'(c));
      ctrl_wr[c] = reg_wr & (adr_ch == 4'(c));
      tx_push[c] = stream_act & op_we & op_sel[c] & tx_space[c];
      rx_pop[c]  = stream_act & ~op_we & op_sel[c] & rx_has[c];
      if (op_sel[c]) op_rx_data = rx_mem[c][rx_rp[c][AW-1:0]];
      if (adr_ch == 4'(c)) begin
        reg_rdata = wbs_adr_i[2] ? {30'b0, irq_en[c], last_arm[c]}
                                 : {12'b0, timeout_err[c], rx_last_seen[c], ~rx_has[c],
                                    ~tx_space[c], 8'(rx_cnt[c]), 8'(tx_cnt[c])};
      end
    end
    op_space    = |(op_sel & tx_space);
    op_avail    = |(op_sel & rx_has);
    timeout_hit = (state == S_WAIT) & req & ~cur_we & ~op_avail & (wait_cnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= S_IDLE;
      cur_ch    <= '0;
      cur_we    <= 1'b0;
      wait_cnt  <= '0;
      wbs_dat_o <= '0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (hit) begin
            cur_ch   <= adr_ch;
            cur_we   <= wbs_we_i;
            wait_cnt <= '0;
            if (!ch_ok || !sel_ok || !wbs_adr_i[7]) begin
              state <= S_ACK;
              if (!wbs_we_i) wbs_dat_o <= (ch_ok && sel_ok) ? reg_rdata : '0;
            end else if (wbs_we_i) begin
              state <= op_space ? S_ACK : S_WAIT;
            end else if (op_avail) begin
              wbs_dat_o <= op_rx_data;
              state     <= S_ACK;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (cur_we) begin
            if (op_space) state <= S_ACK;
          end else if (op_avail) begin
            wbs_dat_o <= op_rx_data;
            state     <= S_ACK;
          end else if (timeout_hit) begin
            wbs_dat_o <= 32'hDEAD_BEEF;
            state     <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        tx_wp[c] <= '0;
        tx_rp[c] <= '0;
        rx_wp[c] <= '0;
        rx_rp[c] <= '0;
      end
      last_arm     <= '0;
      irq_en       <= '0;
      rx_last_seen <= '0;
      timeout_err  <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (tx_push[c]) tx_wp[c] <= tx_wp[c] + 1'b1;
        if (tx_pop[c])  tx_rp[c] <= tx_rp[c] + 1'b1;
        if (rx_push[c]) rx_wp[c] <= rx_wp[c] + 1'b1;
        if (rx_pop[c])  rx_rp[c] <= rx_rp[c] + 1'b1;
        if (ctrl_wr[c]) begin
          last_arm[c] <= wbs_dat_i[0];
          irq_en[c]   <= wbs_dat_i[1];
        end else if (tx_push[c]) begin
          last_arm[c] <= 1'b0;
        end
        // Clear first so a same-cycle event still leaves the sticky bit set.
        if (ctrl_wr[c] && wbs_dat_i[2]) begin
          rx_last_seen[c] <= 1'b0;
          timeout_err[c]  <= 1'b0;
        end
        if (rx_push[c] && sm_tlast[c]) rx_last_seen[c] <= 1'b1;
        if (timeout_hit && op_sel[c])  timeout_err[c]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (tx_push[c]) tx_mem[c][tx_wp[c][AW-1:0]] <= {last_arm[c], wbs_dat_i};
      if (rx_push[c]) rx_mem[c][rx_wp[c][AW-1:0]] <= sm_tdata[c*DW +: DW];
    end
  end

endmodule

// File: tb/tb_wb_axis_stream_hub.sv
// Directed bench for wb_axis_stream_hub: bus latency, FIFO flow, timeout, tlast arming, irq and reset.
module tb_wb_axis_stream_hub;

  localparam int NCH = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat_o;
  logic [NCH-1:0]  ss_tvalid, ss_tlast, ss_tready;
  logic [NCH*32-1:0] ss_tdata;
  logic [NCH-1:0]  sm_tvalid, sm_tlast, sm_tready;
  logic [NCH*32-1:0] sm_tdata;
  logic [NCH-1:0]  irq;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] txq[$];

  wb_axis_stream_hub #(
    .NCH(NCH), .DW(32), .FIFO_DEPTH(4), .BASE_HI(12'h300), .TIMEOUT(64)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && ss_tvalid[0] && ss_tready[0]) txq.push_back({ss_tlast[0], ss_tdata[31:0]});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int maxw, output logic [31:0] rd, output int lat);
    lat = 0;
    rd  = '0;
    adr = a; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < maxw && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i + 1;
        rd  = rdat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sm_drive(input int ch, input logic [31:0] d0, input logic [31:0] d1);
    sm_tvalid[ch] = 1'b1; sm_tdata[ch*32 +: 32] = d0; sm_tlast[ch] = 1'b0;
    @(posedge clk); #1;
    sm_tdata[ch*32 +: 32] = d1; sm_tlast[ch] = 1'b1;
    @(posedge clk); #1;
    sm_tvalid[ch] = 1'b0; sm_tlast[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, acks;
    logic [31:0] exp_d [5];
    logic        exp_l [5];
    logic [32:0] ent;

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; wdat = '0;
    ss_tready = 3'b001; sm_tvalid = '0; sm_tdata = '0; sm_tlast = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat_o, 32'd0);
    check("rst_ss_tvalid", 32'(ss_tvalid), 32'd0);
    check("rst_ss_tlast", 32'(ss_tlast), 32'd0);
    check("rst_sm_tready", 32'(sm_tready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_sm_tready_pre", 32'(sm_tready), 32'd0);
    @(posedge clk); #1;
    check("rel_sm_tready", 32'(sm_tready), 32'h7);

    // Test 1: three ch0 stream writes, single-cycle ack
    xfer(32'h3000_0080, 1'b1, 32'h11, 8, rd, lat); check("t1_lat0", lat, 1);
    xfer(32'h3000_0080, 1'b1, 32'h22, 8, rd, lat); check("t1_lat1", lat, 1);
    xfer(32'h3000_0080, 1'b1, 32'h33, 8, rd, lat); check("t1_lat2", lat, 1);

    // Test 4: armed last on next push only
    xfer(32'h3000_0004, 1'b1, 32'h1, 8, rd, lat);  check("t4_ctrl_lat", lat, 1);
    xfer(32'h3000_0080, 1'b1, 32'hAA, 8, rd, lat); check("t4_aa_lat", lat, 1);
    xfer(32'h3000_0080, 1'b1, 32'hBB, 8, rd, lat); check("t4_bb_lat", lat, 1);
    xfer(32'h3000_0004, 1'b0, 32'h0, 8, rd, lat);  check("t4_ctrl_rd", rd, 32'h0);
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'hAA; exp_d[4] = 32'hBB;
    exp_l[0] = 1'b0;   exp_l[1] = 1'b0;   exp_l[2] = 1'b0;   exp_l[3] = 1'b1;   exp_l[4] = 1'b0;
    check("t1_q_size", 32'(txq.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      ent = (txq.size() > 0) ? txq.pop_front() : 33'h1_FFFF_FFFF;
      check("t1_ss_tdata", ent[31:0], exp_d[i]);
      check("t4_ss_tlast", 32'(ent[32]), 32'(exp_l[i]));
    end

    // Non-hit address never acks
    xfer(32'h2000_0080, 1'b1, 32'h55, 6, rd, lat); check("nohit_noack", lat, 0);

    // Test 2: ch1 backpressure
    for (int i = 0; i < 4; i++) begin
      xfer(32'h3000_0180, 1'b1, 32'h101 + i, 8, rd, lat);
      check("t2_wr_lat", lat, 1);
    end
    adr = 32'h3000_0180; we = 1'b1; wdat = 32'h105; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check("t2_stall_noack", acks, 0);
    ss_tready[1] = 1'b1;
    lat = 0;
    for (int i = 0; i < 3 && lat == 0; i++) begin
      @(posedge clk); #1;
      ss_tready[1] = 1'b0;
      if (ack) lat = i + 1;
    end
    check("t2_ack_within2", 32'(lat >= 1 && lat <= 2), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    xfer(32'h3000_0100, 1'b0, 32'h0, 8, rd, lat); check("t2_status", rd, 32'h0003_0004);
    check("t2_head", ss_tdata[63:32], 32'h102);

    // Test 3: RX timeout on ch2
    xfer(32'h3000_0280, 1'b0, 32'h0, 100, rd, lat);
    check("t3_lat", lat, 65);
    check("t3_data", rd, 32'hDEAD_BEEF);
    xfer(32'h3000_0380, 1'b0, 32'h0, 8, rd, lat);
    check("badch_lat", lat, 1);
    check("badch_data", rd, 32'h0);
    xfer(32'h3000_0200, 1'b0, 32'h0, 8, rd, lat); check("t3_status_err", rd, 32'h000A_0000);
    xfer(32'h3000_0204, 1'b1, 32'h4, 8, rd, lat);
    xfer(32'h3000_0200, 1'b0, 32'h0, 8, rd, lat); check("t3_status_clr", rd, 32'h0002_0000);

    // Test 5: RX path and irq on ch0
    xfer(32'h3000_0004, 1'b1, 32'h2, 8, rd, lat);
    sm_drive(0, 32'h5, 32'h6);
    check("t5_irq_set", 32'(irq[0]), 32'd1);
    xfer(32'h3000_0000, 1'b0, 32'h0, 8, rd, lat); check("t5_status", rd, 32'h0004_0200);
    xfer(32'h3000_0080, 1'b0, 32'h0, 8, rd, lat); check("t5_rd0", rd, 32'h5); check("t5_rd0_lat", lat, 1);
    xfer(32'h3000_0080, 1'b0, 32'h0, 8, rd, lat); check("t5_rd1", rd, 32'h6);
    check("t5_irq_clr", 32'(irq[0]), 32'd0);

    // Test 6: reset mid-WAIT with ch1 TX full and RX half full
    sm_drive(1, 32'h71, 32'h72);
    adr = 32'h3000_0180; we = 1'b1; wdat = 32'h999; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", 32'(ack), 32'd0);
    check("t6_rst_tvalid", 32'(ss_tvalid), 32'd0);
    check("t6_rst_tready", 32'(sm_tready), 32'd0);
    check("t6_rst_dat", rdat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (ack) acks++;
    check("t6_noack", acks, 0);
    check("t6_sm_tready", 32'(sm_tready), 32'h7);
    xfer(32'h3000_0100, 1'b0, 32'h0, 8, rd, lat); check("t6_status_ch1", rd, 32'h0002_0000);
    xfer(32'h3000_0004, 1'b0, 32'h0, 8, rd, lat); check("t6_ctrl_ch0", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
